uart_byte_receiver: RTL and testbench

Receives asynchronous 8N1 serial frames from the demodulated IrDA line and presents complete bytes to the host logic through a one-byte holding register with a ready/ack handshake. It sits directly downstream of the IrDA demodulator: its serial input is the demodulator's `uart_rx_data` output, registered in the same clock domain. It samples each bit at mid-period, rejects false start bits, and flags framing and overrun errors.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_bit_timer.sv | 41 ++++
 rtl/uart_byte_receiver.sv | 133 +++++++++++++
 tb/tb_uart_byte_receiver.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver, the IrDA demodulator and the future transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  // 9600 baud at a 50 MHz system clock.
  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clocks within a serial bit and flags the half-bit and full-bit points.
// Latency: ticks are combinational decodes of the registered count.
// Backpressure: none; clear wins over enable, count wraps to 0 after the full-bit tick.
// Ports: clock, reset (sync, active-low), clear, enable -> half_tick, full_tick.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic half_tick,
  output logic full_tick
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int TW       = $clog2(CLKS_PER_BIT);

  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_BIT - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] count;

  assign half_tick = (count == HALF_LAST);
  assign full_tick = (count == FULL_LAST);

  // Wrapping at the full-bit point lets consecutive data bits reuse the
  // same count without a state change in between.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= full_tick ? '0 : count + TW'(1);
    end
  end

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver: mid-bit sampling, false-start rejection, one-byte holding register with ready/ack.
// Latency: byte visible on the edge that takes the stop-bit sample (mid stop bit).
// Backpressure: none on the line; an unacked held byte causes newer bytes to be dropped and overrun set.
// Ports: clock, reset (sync, active-low), uart_rx_data, rx_ack -> rx_data, rx_ready, framing_error, overrun, rx_busy.
module uart_byte_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 uart_rx_data,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  uart_state_t          state;
  uart_state_t          state_next;
  logic                 half_tick;
  logic                 full_tick;
  logic                 timer_clr;
  logic                 timer_en;
  logic                 shift_en;
  logic                 stop_sample;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (timer_clr),
    .enable   (timer_en),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!uart_rx_data) state_next = START;
      end
      START: begin
        // Line back high at mid start bit means it was only a glitch.
        if (half_tick) state_next = uart_rx_data ? IDLE : DATA;
      end
      DATA: begin
        if (full_tick && (bit_idx == LAST_IDX)) state_next = STOP;
      end
      STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch the next start edge.
        if (full_tick) state_next = uart_rx_data ? IDLE : BREAK_WAIT;
      end
      BREAK_WAIT: begin
        // A held-low break must not be mistaken for a fresh start bit.
        if (uart_rx_data) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode.
  always_comb begin
    rx_busy     = (state != IDLE);
    timer_en    = (state != IDLE);
    timer_clr   = (state_next != state);
    shift_en    = (state == DATA) && full_tick;
    stop_sample = (state == STOP) && full_tick;
  end

  // Shifter, bit index and holding register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      bit_idx       <= '0;
      shift_reg     <= '0;
      rx_data       <= '0;
      rx_ready      <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= 1'b0;

      if (state == START) begin
        bit_idx <= '0;
      end

      // LSB arrives first: shift right, new bit at the MSB.
      if (shift_en) begin
        shift_reg <= {uart_rx_data, shift_reg[DATA_BITS-1:1]};
        bit_idx   <= bit_idx + 3'd1;
      end

      if (rx_ready && rx_ack) begin
        rx_ready <= 1'b0;
        overrun  <= 1'b0;
      end

      // A byte completing in the same cycle as an ack replaces the old one
      // cleanly; the later assignment keeps rx_ready high.
      if (stop_sample) begin
        if (uart_rx_data) begin
          if (!rx_ready || rx_ack) begin
            rx_data  <= shift_reg;
            rx_ready <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          framing_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench for uart_byte_receiver at 16 clocks/bit plus one frame at 5208 clocks/bit.
// Latency: stop sample at 9*CPB+HALF cycles after the start edge; outputs checked one cycle before and after.
// Backpressure: exercises ack, no-ack overrun and ack-on-stop-sample cases.
module tb_uart_byte_receiver;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int SLOW = 5208;

  logic       clock;
  logic       reset;
  logic       line;
  logic       ack;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       framing_error;
  logic       overrun;
  logic       rx_busy;

  logic       line_s;
  logic       ack_s;
  logic [7:0] rx_data_s;
  logic       rx_ready_s;
  logic       framing_error_s;
  logic       overrun_s;
  logic       rx_busy_s;

  int compared;
  int mismatched;

  uart_byte_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clock        (clock),
    .reset        (reset),
    .uart_rx_data (line),
    .rx_ack       (ack),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .framing_error(framing_error),
    .overrun      (overrun),
    .rx_busy      (rx_busy)
  );

  uart_byte_receiver #(.CLKS_PER_BIT(SLOW)) dut_slow (
    .clock        (clock),
    .reset        (reset),
    .uart_rx_data (line_s),
    .rx_ack       (ack_s),
    .rx_data      (rx_data_s),
    .rx_ready     (rx_ready_s),
    .framing_error(framing_error_s),
    .overrun      (overrun_s),
    .rx_busy      (rx_busy_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives start + 8 data bits, sets the stop level, and returns on the
  // negedge just before the stop-sample posedge.
  task automatic send_head(input logic [7:0] b, input logic stop_bit);
    line = 1'b0;
    repeat (CPB) tick();
    for (int k = 0; k < 8; k++) begin
      line = b[k];
      repeat (CPB) tick();
    end
    line = stop_bit;
    repeat (HALF) tick();
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_head(b, 1'b1);
    repeat (CPB - HALF) tick();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_data"},  32'(rx_data),       32'h00);
    check({pfx, "_ready"}, 32'(rx_ready),      32'h0);
    check({pfx, "_fe"},    32'(framing_error), 32'h0);
    check({pfx, "_ovr"},   32'(overrun),       32'h0);
    check({pfx, "_busy"},  32'(rx_busy),       32'h0);
  endtask

  initial begin
    logic [7:0] pat;
    compared   = 0;
    mismatched = 0;
    reset  = 1'b0;
    line   = 1'b1;
    ack    = 1'b0;
    line_s = 1'b1;
    ack_s  = 1'b0;

    // Reset state.
    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b1;
    repeat (2) tick();

    // Frame 0xA5, exact stop-sample timing, then ack.
    send_head(8'hA5, 1'b1);
    check("a5_pre_ready", 32'(rx_ready), 32'h0);
    check("a5_pre_busy",  32'(rx_busy),  32'h1);
    tick();
    check("a5_ready", 32'(rx_ready),      32'h1);
    check("a5_data",  32'(rx_data),       32'hA5);
    check("a5_fe",    32'(framing_error), 32'h0);
    check("a5_busy",  32'(rx_busy),       32'h0);
    repeat (CPB - HALF - 1) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("a5_ack_ready", 32'(rx_ready), 32'h0);
    check("a5_ack_data",  32'(rx_data),  32'hA5);
    repeat (4) tick();

    // 3-cycle glitch: START for HALF cycles, then back to IDLE.
    line = 1'b0;
    tick();
    check("gl_busy_start", 32'(rx_busy), 32'h1);
    repeat (2) tick();
    line = 1'b1;
    repeat (5) tick();
    check("gl_busy_before", 32'(rx_busy), 32'h1);
    tick();
    check("gl_busy_after", 32'(rx_busy),       32'h0);
    check("gl_ready",      32'(rx_ready),      32'h0);
    check("gl_fe",         32'(framing_error), 32'h0);
    check("gl_ovr",        32'(overrun),       32'h0);
    repeat (4) tick();

    // Frame 0x3C with low stop, break held 40 cycles, then 0x55.
    send_head(8'h3C, 1'b0);
    check("brk_fe_pre", 32'(framing_error), 32'h0);
    tick();
    check("brk_fe",    32'(framing_error), 32'h1);
    check("brk_ready", 32'(rx_ready),      32'h0);
    check("brk_busy",  32'(rx_busy),       32'h1);
    tick();
    check("brk_fe_pulse", 32'(framing_error), 32'h0);
    repeat (30) tick();
    line = 1'b1;
    tick();
    check("brk_idle", 32'(rx_busy),  32'h0);
    check("brk_ready_after", 32'(rx_ready), 32'h0);
    repeat (4) tick();
    send_head(8'h55, 1'b1);
    tick();
    check("x55_ready", 32'(rx_ready),      32'h1);
    check("x55_data",  32'(rx_data),       32'h55);
    check("x55_fe",    32'(framing_error), 32'h0);
    repeat (CPB - HALF - 1) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // 0x11 then 0x22 without ack: overrun, old byte kept.
    send_frame(8'h11);
    send_head(8'h22, 1'b1);
    check("ovr_pre", 32'(overrun), 32'h0);
    tick();
    check("ovr_flag",  32'(overrun),  32'h1);
    check("ovr_data",  32'(rx_data),  32'h11);
    check("ovr_ready", 32'(rx_ready), 32'h1);
    repeat (CPB - HALF - 1) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ovr_clr_ready", 32'(rx_ready), 32'h0);
    check("ovr_clr_flag",  32'(overrun),  32'h0);
    check("ovr_clr_data",  32'(rx_data),  32'h11);

    // 0x11 then 0x22 with ack on the stop-sample cycle.
    send_frame(8'h11);
    send_head(8'h22, 1'b1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ackst_data",  32'(rx_data),  32'h22);
    check("ackst_ready", 32'(rx_ready), 32'h1);
    check("ackst_ovr",   32'(overrun),  32'h0);
    repeat (CPB - HALF - 1) tick();

    // Reset in the middle of data bit 4 (rx_ready still 1 from 0x22).
    pat  = 8'h7E;
    line = 1'b0;
    repeat (CPB) tick();
    for (int k = 0; k < 4; k++) begin
      line = pat[k];
      repeat (CPB) tick();
    end
    line = pat[4];
    repeat (HALF) tick();
    reset = 1'b0;
    tick();
    check_reset_outputs("mid");
    reset = 1'b1;
    line  = 1'b1;
    repeat (2 * CPB) tick();
    send_head(8'h7E, 1'b1);
    tick();
    check("x7e_ready", 32'(rx_ready),      32'h1);
    check("x7e_data",  32'(rx_data),       32'h7E);
    check("x7e_fe",    32'(framing_error), 32'h0);
    check("x7e_ovr",   32'(overrun),       32'h0);
    repeat (CPB - HALF - 1) tick();

    // One frame at the default 5208 clocks per bit.
    pat    = 8'hA5;
    line_s = 1'b0;
    repeat (SLOW) tick();
    for (int k = 0; k < 8; k++) begin
      line_s = pat[k];
      repeat (SLOW) tick();
    end
    line_s = 1'b1;
    repeat (SLOW / 2) tick();
    check("slow_pre_ready", 32'(rx_ready_s), 32'h0);
    tick();
    check("slow_ready", 32'(rx_ready_s),      32'h1);
    check("slow_data",  32'(rx_data_s),       32'hA5);
    check("slow_fe",    32'(framing_error_s), 32'h0);
    check("slow_busy",  32'(rx_busy_s),       32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
